conv_unit_driver: RTL and testbench

Initiator-side sequencer for conv_unit. It streams weights, ifmap and ipsum words from a local buffer onto the shared 32-bit data_in bus using conv_unit's valid/ready handshakes, then drains opsum words from data_out back into the buffer. One start pulse runs one complete tile pass: W -> IF -> IP -> OP. The layer controller above it configures and triggers each pass.

---
 rtl/conv_unit_driver.sv | 187 ++++++++++++++++++
 tb/tb_conv_unit_driver.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_unit_driver.sv
// Initiator-side sequencer for conv_unit: streams W/IF/IP words from the local buffer
// onto data_in through a 2-entry prefetch FIFO, then drains opsums back into the buffer.
module conv_unit_driver #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 16,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              cfg_dw_pw_sel,
   input  logic [CNT_W-1:0]  cfg_w_num,
   input  logic [CNT_W-1:0]  cfg_if_num,
   input  logic [CNT_W-1:0]  cfg_ip_num,
   input  logic [CNT_W-1:0]  cfg_op_num,
   input  logic [ADDR_W-1:0] cfg_w_base,
   input  logic [ADDR_W-1:0] cfg_if_base,
   input  logic [ADDR_W-1:0] cfg_ip_base,
   input  logic [ADDR_W-1:0] cfg_op_base,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_wr_addr,
   output logic [DATA_W-1:0] mem_wr_data,
   output logic              DW_PW_sel,
   output logic              change_weight_f,
   output logic              valid_w,
   input  logic              ready_w,
   output logic              valid_if,
   input  logic              ready_if,
   output logic              valid_ip,
   input  logic              ready_ip,
   input  logic              valid_op,
   output logic              ready_op,
   output logic [DATA_W-1:0] data_in,
   input  logic [DATA_W-1:0] data_out,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_IF, LOAD_IP, DRAIN_OP, FIN} state_t;

   state_t            state;
   state_t            following;
   logic [CNT_W-1:0]  w_num, if_num, ip_num, op_num;
   logic [CNT_W-1:0]  cur_num, reads_issued, beats;
   logic [ADDR_W-1:0] if_base, ip_base, op_base, rd_addr, entry_base;
   logic [DATA_W-1:0] fifo_mem [2];
   logic              fifo_head, fifo_tail;
   logic [1:0]        fifo_count;
   logic              rd_pend;
   logic              loading, ready_sel, pop, issue, op_fire, phase_exit;
   logic [3:0]        nz;

   // First phase with a nonzero count, in W, IF, IP, OP order; FIN when none remain.
   function automatic state_t pick(input logic [3:0] m);
      state_t s;
      if (m[0])      s = LOAD_W;
      else if (m[1]) s = LOAD_IF;
      else if (m[2]) s = LOAD_IP;
      else if (m[3]) s = DRAIN_OP;
      else           s = FIN;
      return s;
   endfunction

   always_comb begin
      loading    = (state == LOAD_W) || (state == LOAD_IF) || (state == LOAD_IP);
      cur_num    = '0;
      ready_sel  = 1'b0;
      nz         = 4'b0000;
      entry_base = '0;
      case (state)
         LOAD_W:   begin cur_num = w_num;  ready_sel = ready_w;  end
         LOAD_IF:  begin cur_num = if_num; ready_sel = ready_if; end
         LOAD_IP:  begin cur_num = ip_num; ready_sel = ready_ip; end
         DRAIN_OP: cur_num = op_num;
         default:  cur_num = '0;
      endcase
      pop     = loading && (fifo_count != 2'd0) && ready_sel;
      // A pop this cycle frees a slot, so it is credited to keep one beat per cycle.
      issue   = loading && (reads_issued < cur_num) &&
                (({1'b0, fifo_count} + {2'b00, rd_pend}) < (pop ? 3'd3 : 3'd2));
      op_fire = (state == DRAIN_OP) && valid_op;
      phase_exit = (pop || op_fire) && (beats == cur_num - CNT_W'(1));
      case (state)
         IDLE:    nz = {cfg_op_num != '0, cfg_ip_num != '0, cfg_if_num != '0, cfg_w_num != '0};
         LOAD_W:  nz = {op_num != '0, ip_num != '0, if_num != '0, 1'b0};
         LOAD_IF: nz = {op_num != '0, ip_num != '0, 2'b00};
         LOAD_IP: nz = {op_num != '0, 3'b000};
         default: nz = 4'b0000;
      endcase
      following = pick(nz);
      case (following)
         LOAD_W:  entry_base = cfg_w_base;
         LOAD_IF: entry_base = (state == IDLE) ? cfg_if_base : if_base;
         LOAD_IP: entry_base = (state == IDLE) ? cfg_ip_base : ip_base;
         default: entry_base = '0;
      endcase
   end

   assign mem_rd_en       = issue;
   assign mem_rd_addr     = rd_addr;
   assign data_in         = fifo_mem[fifo_head];
   assign valid_w         = (state == LOAD_W)  && (fifo_count != 2'd0);
   assign valid_if        = (state == LOAD_IF) && (fifo_count != 2'd0);
   assign valid_ip        = (state == LOAD_IP) && (fifo_count != 2'd0);
   assign ready_op        = (state == DRAIN_OP);
   assign change_weight_f = (state == LOAD_W);
   assign busy            = (state != IDLE);
   assign done            = (state == FIN);

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         w_num        <= '0;
         if_num       <= '0;
         ip_num       <= '0;
         op_num       <= '0;
         if_base      <= '0;
         ip_base      <= '0;
         op_base      <= '0;
         rd_addr      <= '0;
         reads_issued <= '0;
         beats        <= '0;
         fifo_mem[0]  <= '0;
         fifo_mem[1]  <= '0;
         fifo_head    <= 1'b0;
         fifo_tail    <= 1'b0;
         fifo_count   <= 2'd0;
         rd_pend      <= 1'b0;
         mem_wr_en    <= 1'b0;
         mem_wr_addr  <= '0;
         mem_wr_data  <= '0;
         DW_PW_sel    <= 1'b0;
      end else begin
         rd_pend   <= issue;
         mem_wr_en <= op_fire;
         if (op_fire) begin
            mem_wr_addr <= op_base + ADDR_W'(beats);
            mem_wr_data <= data_out;
         end
         if (rd_pend) begin
            fifo_mem[fifo_tail] <= mem_rd_data;
            fifo_tail           <= ~fifo_tail;
         end
         if (pop)
            fifo_head <= ~fifo_head;
         fifo_count <= fifo_count + {1'b0, rd_pend} - {1'b0, pop};
         if (issue) begin
            rd_addr      <= rd_addr + ADDR_W'(1);
            reads_issued <= reads_issued + CNT_W'(1);
         end
         if (pop || op_fire)
            beats <= beats + CNT_W'(1);
         case (state)
            IDLE: begin
               if (start) begin
                  w_num        <= cfg_w_num;
                  if_num       <= cfg_if_num;
                  ip_num       <= cfg_ip_num;
                  op_num       <= cfg_op_num;
                  if_base      <= cfg_if_base;
                  ip_base      <= cfg_ip_base;
                  op_base      <= cfg_op_base;
                  DW_PW_sel    <= cfg_dw_pw_sel;
                  state        <= following;
                  rd_addr      <= entry_base;
                  reads_issued <= '0;
                  beats        <= '0;
               end
            end
            LOAD_W, LOAD_IF, LOAD_IP, DRAIN_OP: begin
               if (phase_exit) begin
                  state        <= following;
                  rd_addr      <= entry_base;
                  reads_issued <= '0;
                  beats        <= '0;
               end
            end
            FIN:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_unit_driver.sv
// Directed bench for conv_unit_driver: behavioural buffer and opsum source, a negedge
// monitor that logs every transfer, and hand-computed expectations per pass.
module tb_conv_unit_driver;
   logic        clk = 1'b0;
   logic        reset, start, cfg_dw_pw_sel;
   logic [15:0] cfg_w_num, cfg_if_num, cfg_ip_num, cfg_op_num;
   logic [15:0] cfg_w_base, cfg_if_base, cfg_ip_base, cfg_op_base;
   logic        mem_rd_en, mem_wr_en;
   logic [15:0] mem_rd_addr, mem_wr_addr;
   logic [31:0] mem_rd_data = '0;
   logic [31:0] mem_wr_data, data_in, data_out;
   logic        DW_PW_sel, change_weight_f, busy, done;
   logic        valid_w, valid_if, valid_ip, valid_op;
   logic        ready_w, ready_if, ready_ip, ready_op;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   conv_unit_driver dut (
      .clk(clk), .reset(reset), .start(start), .cfg_dw_pw_sel(cfg_dw_pw_sel),
      .cfg_w_num(cfg_w_num), .cfg_if_num(cfg_if_num), .cfg_ip_num(cfg_ip_num),
      .cfg_op_num(cfg_op_num), .cfg_w_base(cfg_w_base), .cfg_if_base(cfg_if_base),
      .cfg_ip_base(cfg_ip_base), .cfg_op_base(cfg_op_base),
      .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
      .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
      .DW_PW_sel(DW_PW_sel), .change_weight_f(change_weight_f),
      .valid_w(valid_w), .ready_w(ready_w), .valid_if(valid_if), .ready_if(ready_if),
      .valid_ip(valid_ip), .ready_ip(ready_ip), .valid_op(valid_op), .ready_op(ready_op),
      .data_in(data_in), .data_out(data_out), .busy(busy), .done(done)
   );

   function automatic logic [31:0] memfn(input logic [15:0] a);
      return {~a, a};
   endfunction

   // Buffer model: data for an accepted read appears in the following cycle.
   always @(posedge clk)
      if (mem_rd_en) mem_rd_data <= memfn(mem_rd_addr);

   // Opsum source: presents op_words in order, advancing on each accepted beat.
   logic [31:0] op_words [4];
   int          op_len = 0;
   int          op_idx = 0;
   logic        op_clr = 1'b0;
   logic [1:0]  op_sel;
   assign op_sel   = op_idx[1:0];
   assign valid_op = (op_idx < op_len);
   assign data_out = valid_op ? op_words[op_sel] : 32'hDEAD_0000;
   always @(posedge clk)
      if (op_clr) op_idx <= 0;
      else if (valid_op && ready_op) op_idx <= op_idx + 1;

   // Monitor: logs transfers, reads, writes, done pulses and protocol violations.
   logic [31:0] w_log[$], if_log[$], ip_log[$], wr_data_log[$];
   logic [15:0] rd_log[$], wr_addr_log[$];
   int done_cnt = 0, vw_cnt = 0, vip_cnt = 0, hold_err = 0, multi_err = 0, cw_err = 0;
   int last_if_cyc = 0, last_done_cyc = 0, cyc = 0;
   logic pv = 1'b0, pr = 1'b0;
   logic [31:0] pd = '0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!reset) begin
         if (valid_w && ready_w) begin
            w_log.push_back(data_in);
            if (!change_weight_f) cw_err++;
         end
         if (valid_if && ready_if) begin
            if_log.push_back(data_in);
            last_if_cyc = cyc;
         end
         if (valid_ip && ready_ip) ip_log.push_back(data_in);
         if (mem_rd_en) rd_log.push_back(mem_rd_addr);
         if (mem_wr_en) begin
            wr_addr_log.push_back(mem_wr_addr);
            wr_data_log.push_back(mem_wr_data);
         end
         if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
         end
         if (valid_w) vw_cnt++;
         if (valid_ip) vip_cnt++;
         if ((int'(valid_w) + int'(valid_if) + int'(valid_ip)) > 1) multi_err++;
         if (pv && !pr && (!(valid_w | valid_if | valid_ip) || data_in !== pd)) hold_err++;
         pv = valid_w | valid_if | valid_ip;
         pr = (valid_w & ready_w) | (valid_if & ready_if) | (valid_ip & ready_ip);
         pd = data_in;
      end else begin
         pv = 1'b0;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic applyStimulus(input logic dw, input logic [15:0] wn, input logic [15:0] ifn,
                                input logic [15:0] ipn, input logic [15:0] opn,
                                input logic [15:0] wb, input logic [15:0] ifb,
                                input logic [15:0] ipb, input logic [15:0] opb);
      cfg_dw_pw_sel = dw;
      cfg_w_num = wn;   cfg_if_num = ifn;  cfg_ip_num = ipn;  cfg_op_num = opn;
      cfg_w_base = wb;  cfg_if_base = ifb; cfg_ip_base = ipb; cfg_op_base = opb;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic waitIdle(input string tag);
      int n = 0;
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput({tag, "_finish"}, 32'(busy), 32'd0);
      tick();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int wb, ib, pb, rb, wrb, db, vwb, vpb, he;
      logic [5:0] pat;
      reset = 1'b1; start = 1'b0;
      cfg_dw_pw_sel = 1'b0;
      cfg_w_num = '0; cfg_if_num = '0; cfg_ip_num = '0; cfg_op_num = '0;
      cfg_w_base = '0; cfg_if_base = '0; cfg_ip_base = '0; cfg_op_base = '0;
      ready_w = 1'b1; ready_if = 1'b1; ready_ip = 1'b1;
      op_clr = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b0;
      op_clr = 1'b0;
      @(negedge clk);
      checkOutput("reset_ctrl", {22'b0, busy, done, valid_w, valid_if, valid_ip, ready_op,
                                 mem_rd_en, mem_wr_en, change_weight_f, DW_PW_sel}, 32'd0);
      checkOutput("reset_data_in", data_in, 32'd0);
      checkOutput("reset_addr", {mem_rd_addr, mem_wr_addr}, 32'd0);
      tick();

      // Pass 1: full W/IF/IP/OP with ready held high.
      op_words[0] = 32'h0000_A5A5; op_words[1] = 32'h0000_5A5A; op_len = 2;
      wb = w_log.size(); ib = if_log.size(); pb = ip_log.size();
      rb = rd_log.size(); wrb = wr_addr_log.size(); db = done_cnt;
      applyStimulus(1'b1, 16'd4, 16'd3, 16'd2, 16'd2, 16'h0100, 16'h0200, 16'h0300, 16'h0400);
      @(negedge clk);
      checkOutput("t1_enter_w", {29'b0, busy, change_weight_f, valid_w}, 32'b110);
      @(negedge clk);
      checkOutput("t1_lat1", 32'(valid_w), 32'd0);
      @(negedge clk);
      checkOutput("t1_first_valid", 32'(valid_w), 32'd1);
      checkOutput("t1_first_word", data_in, memfn(16'h0100));
      waitIdle("t1");
      checkOutput("t1_w_cnt", 32'(w_log.size() - wb), 32'd4);
      for (int k = 0; k < 4; k++) checkOutput("t1_w_word", w_log[wb+k], memfn(16'h0100 + 16'(k)));
      checkOutput("t1_if_cnt", 32'(if_log.size() - ib), 32'd3);
      for (int k = 0; k < 3; k++) checkOutput("t1_if_word", if_log[ib+k], memfn(16'h0200 + 16'(k)));
      checkOutput("t1_ip_cnt", 32'(ip_log.size() - pb), 32'd2);
      for (int k = 0; k < 2; k++) checkOutput("t1_ip_word", ip_log[pb+k], memfn(16'h0300 + 16'(k)));
      checkOutput("t1_reads", 32'(rd_log.size() - rb), 32'd9);
      checkOutput("t1_wr_cnt", 32'(wr_addr_log.size() - wrb), 32'd2);
      checkOutput("t1_wr0_addr", 32'(wr_addr_log[wrb]), 32'h0400);
      checkOutput("t1_wr0_data", wr_data_log[wrb], 32'h0000_A5A5);
      checkOutput("t1_wr1_addr", 32'(wr_addr_log[wrb+1]), 32'h0401);
      checkOutput("t1_wr1_data", wr_data_log[wrb+1], 32'h0000_5A5A);
      checkOutput("t1_done", 32'(done_cnt - db), 32'd1);
      checkOutput("t1_dwpw", 32'(DW_PW_sel), 32'd1);

      // Pass 2: IF backpressure pattern 1,0,0,1,0,1 starting at the first valid cycle.
      ib = if_log.size(); he = hold_err; db = done_cnt;
      pat = 6'b101001;
      applyStimulus(1'b0, 16'd0, 16'd3, 16'd0, 16'd0, 16'h0000, 16'h0A00, 16'h0000, 16'h0000);
      tick();
      tick();
      for (int i = 0; i < 6; i++) begin
         ready_if = pat[i];
         tick();
      end
      ready_if = 1'b1;
      waitIdle("t2");
      checkOutput("t2_if_cnt", 32'(if_log.size() - ib), 32'd3);
      for (int k = 0; k < 3; k++) checkOutput("t2_if_word", if_log[ib+k], memfn(16'h0A00 + 16'(k)));
      checkOutput("t2_hold", 32'(hold_err - he), 32'd0);
      checkOutput("t2_done", 32'(done_cnt - db), 32'd1);

      // Pass 3: only a single IF beat.
      ib = if_log.size(); vwb = vw_cnt; vpb = vip_cnt; db = done_cnt;
      applyStimulus(1'b0, 16'd0, 16'd1, 16'd0, 16'd0, 16'h0000, 16'h0B00, 16'h0000, 16'h0000);
      waitIdle("t3");
      checkOutput("t3_if_cnt", 32'(if_log.size() - ib), 32'd1);
      checkOutput("t3_if_word", if_log[ib], memfn(16'h0B00));
      checkOutput("t3_no_valid_w", 32'(vw_cnt - vwb), 32'd0);
      checkOutput("t3_no_valid_ip", 32'(vip_cnt - vpb), 32'd0);
      checkOutput("t3_done_lat", 32'(last_done_cyc - last_if_cyc), 32'd1);
      checkOutput("t3_done", 32'(done_cnt - db), 32'd1);

      // Pass 4: weight address wrap-around.
      rb = rd_log.size(); wb = w_log.size();
      applyStimulus(1'b0, 16'd3, 16'd0, 16'd0, 16'd0, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000);
      waitIdle("t4");
      checkOutput("t4_reads", 32'(rd_log.size() - rb), 32'd3);
      checkOutput("t4_rd0", 32'(rd_log[rb]), 32'h0000_FFFF);
      checkOutput("t4_rd1", 32'(rd_log[rb+1]), 32'h0000_0000);
      checkOutput("t4_rd2", 32'(rd_log[rb+2]), 32'h0000_0001);
      checkOutput("t4_w2_word", w_log[wb+2], memfn(16'h0001));

      // Pass 5: reset during LOAD_IF after the first IF beat, then a clean restart.
      ib = if_log.size(); db = done_cnt;
      applyStimulus(1'b1, 16'd2, 16'd3, 16'd0, 16'd0, 16'h0C00, 16'h0D00, 16'h0000, 16'h0000);
      begin
         int n = 0;
         while (if_log.size() < ib + 1 && n < 100) begin
            @(negedge clk);
            n++;
         end
      end
      checkOutput("t5_reach_if", 32'(if_log.size() - ib), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("t5_rst_ctrl", {22'b0, busy, done, valid_w, valid_if, valid_ip, ready_op,
                                  mem_rd_en, mem_wr_en, change_weight_f, DW_PW_sel}, 32'd0);
      checkOutput("t5_rst_data_in", data_in, 32'd0);
      checkOutput("t5_rst_addr", {mem_rd_addr, mem_wr_addr}, 32'd0);
      checkOutput("t5_rst_wr_data", mem_wr_data, 32'd0);
      tick();
      reset = 1'b0;
      repeat (3) tick();
      checkOutput("t5_no_done", 32'(done_cnt - db), 32'd0);
      wb = w_log.size(); ib = if_log.size(); db = done_cnt;
      applyStimulus(1'b0, 16'd2, 16'd1, 16'd0, 16'd0, 16'h0E00, 16'h0F00, 16'h0000, 16'h0000);
      waitIdle("t5b");
      checkOutput("t5_w_cnt", 32'(w_log.size() - wb), 32'd2);
      checkOutput("t5_w0_word", w_log[wb], memfn(16'h0E00));
      checkOutput("t5_if_word", if_log[ib], memfn(16'h0F00));
      checkOutput("t5_done", 32'(done_cnt - db), 32'd1);

      // Pass 6: a second start while busy is ignored.
      op_clr = 1'b1;
      tick();
      op_clr = 1'b0;
      op_words[0] = 32'h0000_1234; op_len = 1;
      wb = w_log.size(); wrb = wr_addr_log.size(); db = done_cnt;
      applyStimulus(1'b1, 16'd2, 16'd0, 16'd0, 16'd1, 16'h0000, 16'h0000, 16'h0000, 16'h0500);
      cfg_w_num = 16'd5; cfg_op_base = 16'h0600; cfg_dw_pw_sel = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      waitIdle("t6");
      checkOutput("t6_w_cnt", 32'(w_log.size() - wb), 32'd2);
      checkOutput("t6_wr_cnt", 32'(wr_addr_log.size() - wrb), 32'd1);
      checkOutput("t6_wr_addr", 32'(wr_addr_log[wrb]), 32'h0500);
      checkOutput("t6_wr_data", wr_data_log[wrb], 32'h0000_1234);
      checkOutput("t6_done", 32'(done_cnt - db), 32'd1);
      checkOutput("t6_dwpw", 32'(DW_PW_sel), 32'd1);

      checkOutput("multi_valid", 32'(multi_err), 32'd0);
      checkOutput("cw_flag", 32'(cw_err), 32'd0);
      checkOutput("hold_all", 32'(hold_err), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
